fifo_read_adapter: RTL and testbench

Read-side stage placed directly downstream of the team's synchronous FIFO. Drives the FIFO's `rd_en`, captures `data_out` one cycle later, and re-presents the words on a valid/ready stream through a 2-entry output buffer. It sustains one word per cycle with no bubbles and never reads an empty FIFO. It also counts delivered words and latches a sticky error if the FIFO ever reports underflow.

---
 rtl/fifo_read_adapter_if.sv | 48 ++++
 rtl/fifo_read_adapter.sv | 74 +++++++
 tb/tb_fifo_read_adapter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_read_adapter_if.sv
// Bundle of FIFO read-port and output-stream signals for fifo_read_adapter.
// The master modport is the adapter's view. The slave modport is the view of the
// surrounding FIFO plus the stream consumer.
interface fifo_read_adapter_if #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 32
);

  // FIFO read side
  logic                  fifo_empty;
  logic                  fifo_underflow;
  logic [FIFO_WIDTH-1:0] fifo_data_out;
  logic                  fifo_rd_en;

  // Output stream side
  logic                  m_valid;
  logic                  m_ready;
  logic [FIFO_WIDTH-1:0] m_data;

  // Status
  logic [CNT_WIDTH-1:0]  words_out;
  logic                  err_underflow;

  modport master (
    input  fifo_empty,
    input  fifo_underflow,
    input  fifo_data_out,
    input  m_ready,
    output fifo_rd_en,
    output m_valid,
    output m_data,
    output words_out,
    output err_underflow
  );

  modport slave (
    output fifo_empty,
    output fifo_underflow,
    output fifo_data_out,
    output m_ready,
    input  fifo_rd_en,
    input  m_valid,
    input  m_data,
    input  words_out,
    input  err_underflow
  );

endinterface

// File: rtl/fifo_read_adapter.sv
// Read-side adapter for a synchronous FIFO with one cycle of read latency.
// It issues rd_en, captures the returned word one cycle later into a 2-entry
// buffer, and re-presents the words on a valid/ready stream at one word per cycle.
// It also counts delivered words and keeps a sticky underflow error flag.
module fifo_read_adapter #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input logic                 clk,
  input logic                 rst,
  fifo_read_adapter_if.master bus
);

  logic [FIFO_WIDTH-1:0] buf_mem_q [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0]  words_q, words_d;
  logic                  err_q, err_d;

  logic                  pop;
  logic [2:0]            occ;
  logic                  rd_en;

  // Next-state logic, plus the combinational read strobe.
  // The read strobe counts the word leaving this cycle as free space.
  // This keeps the pipeline full, so throughput is one word per cycle.
  always_comb begin
    pop        = (count_q != 2'd0) && bus.m_ready;
    occ        = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_en      = !rst && !bus.fifo_empty && (occ < 3'd2);

    count_d    = occ[1:0];
    inflight_d = rd_en;
    wr_ptr_d   = wr_ptr_q ^ inflight_q;
    rd_ptr_d   = rd_ptr_q ^ pop;
    words_d    = words_q + CNT_WIDTH'(pop);
    err_d      = err_q | bus.fifo_underflow;
  end

  // Control state, with synchronous reset. Reset also drops an in-flight word.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      words_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      words_q    <= words_d;
      err_q      <= err_d;
    end
  end

  // Capture the FIFO word that returns one cycle after the read strobe.
  always_ff @(posedge clk) begin
    if (!rst && inflight_q) begin
      buf_mem_q[wr_ptr_q] <= bus.fifo_data_out;
    end
  end

  assign bus.fifo_rd_en    = rd_en;
  assign bus.m_valid       = (count_q != 2'd0);
  assign bus.m_data        = buf_mem_q[rd_ptr_q];
  assign bus.words_out     = words_q;
  assign bus.err_underflow = err_q;

endmodule

// File: tb/tb_fifo_read_adapter.sv
// Scoreboard bench for fifo_read_adapter.
// A behavioural synchronous FIFO feeds the DUT. Every word written into it is
// pushed onto the expected queue, and a separate monitor pops and compares each
// word accepted on the output stream.
module tb_fifo_read_adapter;

  localparam int unsigned W = 16;
  localparam int unsigned C = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_read_adapter_if #(.FIFO_WIDTH(W), .CNT_WIDTH(C)) bus ();

  fifo_read_adapter #(.FIFO_WIDTH(W), .CNT_WIDTH(C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural FIFO model. hold_empty lets the bench preload words unseen.
  logic [W-1:0] fifo_q [$];
  logic         model_empty = 1'b1;
  logic         hold_empty  = 1'b0;
  logic         wr_en       = 1'b0;
  logic [W-1:0] wr_data     = '0;

  assign bus.fifo_empty = model_empty | hold_empty;

  always @(posedge clk) begin
    if (rst) begin
      fifo_q.delete();
      model_empty <= 1'b1;
    end else begin
      if (bus.fifo_rd_en && fifo_q.size() != 0) bus.fifo_data_out <= fifo_q.pop_front();
      if (wr_en) fifo_q.push_back(wr_data);
      model_empty <= (fifo_q.size() == 0);
    end
  end

  logic [W-1:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  // Monitor: compares stream output against the scoreboard and checks invariants.
  initial begin
    logic [W-1:0] exp_w;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.fifo_rd_en && bus.fifo_empty) begin
          n_err++;
          $display("FAIL rd_on_empty: fifo_rd_en=1 while fifo_empty=1 at %0t", $time);
        end
        if (dut.count_q > 2'd2) begin
          n_err++;
          $display("FAIL count_range: count=%0d required <=2", dut.count_q);
        end
        if (bus.m_valid && bus.m_ready) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL stream_extra: got %04h, required no word", bus.m_data);
          end else begin
            exp_w = exp_q.pop_front();
            if ($isunknown(bus.m_data) || bus.m_data !== exp_w) begin
              n_err++;
              $display("FAIL stream_data: got %04h required %04h", bus.m_data, exp_w);
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Writes n words base+0..base+n-1 into the FIFO while it still looks empty.
  task automatic preload(input int n, input logic [W-1:0] base);
    hold_empty = 1'b1;
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + W'(i);
      exp_q.push_back(wr_data);
      step();
    end
    wr_en = 1'b0;
    step();
  endtask

  initial begin
    int first_rd, first_v, last_v, n_v, n_rd, pushed, cyc;
    logic [W-1:0] held;

    bus.m_ready        = 1'b0;
    bus.fifo_underflow = 1'b0;
    #1;
    chk("rd_en_in_reset", 64'(bus.fifo_rd_en), 64'd0);
    step();
    step();
    rst = 1'b0;

    // Reset then idle
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("idle_rd_en", 64'(bus.fifo_rd_en), 64'd0);
      chk("idle_m_valid", 64'(bus.m_valid), 64'd0);
      step();
    end
    chk("idle_words_out", 64'(bus.words_out), 64'd0);
    chk("idle_err", 64'(bus.err_underflow), 64'd0);

    // Streaming
    preload(8, 16'h0001);
    bus.m_ready = 1'b1;
    hold_empty  = 1'b0;
    first_rd = -1; first_v = -1; last_v = -1; n_v = 0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (bus.fifo_rd_en && first_rd < 0) first_rd = i;
      if (bus.m_valid) begin
        if (first_v < 0) first_v = i;
        last_v = i;
        n_v++;
      end
      step();
    end
    chk("stream_latency", 64'(first_v - first_rd), 64'd2);
    chk("stream_valid_cycles", 64'(n_v), 64'd8);
    chk("stream_no_bubble", 64'(last_v - first_v + 1), 64'd8);
    chk("stream_words_out", 64'(bus.words_out), 64'd8);
    chk("stream_all_seen", 64'(exp_q.size()), 64'd0);

    // Backpressure
    do_reset();
    bus.m_ready = 1'b0;
    preload(8, 16'h0001);
    hold_empty = 1'b0;
    n_rd = 0;
    held = '0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (bus.fifo_rd_en) n_rd++;
      if (i == 2) held = bus.m_data;
      step();
    end
    #1;
    chk("bp_reads", 64'(n_rd), 64'd2);
    chk("bp_rd_en_low", 64'(bus.fifo_rd_en), 64'd0);
    chk("bp_m_valid", 64'(bus.m_valid), 64'd1);
    chk("bp_m_data_first", 64'(held), 64'h0001);
    chk("bp_m_data_held", 64'(bus.m_data), 64'h0001);
    bus.m_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      step();
      cyc++;
    end
    step();
    chk("bp_drained", 64'(exp_q.size()), 64'd0);
    chk("bp_words_out", 64'(bus.words_out), 64'd8);

    // Random m_ready with random FIFO writes
    do_reset();
    pushed = 0;
    cyc = 0;
    while ((pushed < 1000 || exp_q.size() != 0) && cyc < 20000) begin
      wr_en = (pushed < 1000) && ($urandom_range(0, 1) == 1);
      if (wr_en) begin
        wr_data = W'($urandom);
        exp_q.push_back(wr_data);
        pushed++;
      end
      bus.m_ready = ($urandom_range(0, 1) == 1);
      step();
      cyc++;
    end
    wr_en = 1'b0;
    bus.m_ready = 1'b1;
    step();
    chk("rand_drained", 64'(exp_q.size()), 64'd0);
    chk("rand_words_out", 64'(bus.words_out), 64'd1000);

    // Mid-stream reset with a buffered word and a word in flight
    do_reset();
    bus.m_ready = 1'b0;
    preload(4, 16'h00a0);
    hold_empty = 1'b0;
    step();
    step();
    chk("mid_count_before", 64'(dut.count_q), 64'd1);
    chk("mid_inflight_before", 64'(dut.inflight_q), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rd_en_in_reset", 64'(bus.fifo_rd_en), 64'd0);
    step();
    rst = 1'b0;
    exp_q.delete();
    bus.m_ready = 1'b1;
    chk("mid_m_valid", 64'(bus.m_valid), 64'd0);
    chk("mid_words_out", 64'(bus.words_out), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_no_stale_word", 64'(bus.m_valid), 64'd0);
    end

    // Sticky underflow flag
    chk("uf_before", 64'(bus.err_underflow), 64'd0);
    bus.fifo_underflow = 1'b1;
    step();
    bus.fifo_underflow = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("uf_sticky", 64'(bus.err_underflow), 64'd1);
      step();
    end
    do_reset();
    chk("uf_cleared", 64'(bus.err_underflow), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
